// File: rtl/counter_pkg.sv
// Shared encodings for the modulo-N Counter and its command driver.
// Holds Counter opcodes, driver command codes, FSM states and the opcode-mapping helper.
package counter_pkg;

    localparam logic [2:0] OPC_NOP  = 3'd0;
    localparam logic [2:0] OPC_LOAD = 3'd1;
    localparam logic [2:0] OPC_HOLD = 3'd2;
    localparam logic [2:0] OPC_UP   = 3'd3;
    localparam logic [2:0] OPC_DOWN = 3'd4;

    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_LOAD       = 3'd1;
    localparam logic [2:0] CMD_HOLD_N     = 3'd2;
    localparam logic [2:0] CMD_UP_N       = 3'd3;
    localparam logic [2:0] CMD_DOWN_N     = 3'd4;
    localparam logic [2:0] CMD_UP_UNTIL   = 3'd5;
    localparam logic [2:0] CMD_DOWN_UNTIL = 3'd6;
    localparam logic [2:0] CMD_RSVD       = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_SEEK = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // Counter opcode issued on each counting cycle of a RUN or SEEK command.
    function automatic logic [2:0] step_opcode(input logic [2:0] op);
        case (op)
            CMD_UP_N, CMD_UP_UNTIL:     step_opcode = OPC_UP;
            CMD_DOWN_N, CMD_DOWN_UNTIL: step_opcode = OPC_DOWN;
            default:                    step_opcode = OPC_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/counter_cmd_driver_if.sv
// Command channel into the driver: valid/ready handshake carrying opcode and argument.
// The command source uses master, the driver uses slave.
interface counter_cmd_driver_if #(parameter int ARG_WIDTH = 8);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [ARG_WIDTH-1:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cycle_downcounter.sv
// Loadable down-counter with zero flag; sets RUN length and bounds SEEK.
// Load has priority over decrement; the count saturates at zero.
module cycle_downcounter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_sync,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/counter_cmd_driver.sv
// Turns valid/ready commands into cycle-by-cycle opcodes for the modulo-N Counter.
// Accepts only in IDLE; every command ends with a one-cycle done pulse in FIN.
module counter_cmd_driver
    import counter_pkg::*;
#(
    parameter int N         = 9,
    parameter int WIDTH     = 4,
    parameter int ARG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_sync,
    counter_cmd_driver_if.slave  cmd,
    input  logic [WIDTH-1:0]     cnt_result,
    input  logic                 cnt_y,
    output logic [2:0]           opcode,
    output logic [WIDTH-1:0]     data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ARG_WIDTH-1:0] wrap_cnt
);
    localparam logic [ARG_WIDTH-1:0] N_ARG = ARG_WIDTH'(N);

    logic [2:0]           state, state_nxt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     target_q;
    logic [WIDTH-1:0]     data_q;
    logic [ARG_WIDTH-1:0] wrap_q;
    logic                 err_q;

    logic accept, is_n, is_until, bad_cmd, seek_hit, dc_zero, counting;

    assign accept   = (state == ST_IDLE) && cmd.cmd_valid;
    assign is_n     = (cmd.cmd_op == CMD_HOLD_N) || (cmd.cmd_op == CMD_UP_N) || (cmd.cmd_op == CMD_DOWN_N);
    assign is_until = (cmd.cmd_op == CMD_UP_UNTIL) || (cmd.cmd_op == CMD_DOWN_UNTIL);
    assign bad_cmd  = (cmd.cmd_op == CMD_RSVD) || (is_until && (cmd.cmd_arg >= N_ARG));
    assign seek_hit = (cnt_result == target_q);
    assign counting = (state == ST_RUN) || (state == ST_SEEK);

    // RUN preloads arg-1 so it lasts exactly arg cycles; SEEK allows N steps before timing out.
    cycle_downcounter #(.W(ARG_WIDTH)) u_dc (
        .clk        (clk),
        .reset_sync (reset_sync),
        .load       (accept),
        .load_val   (is_n ? (cmd.cmd_arg - 1'b1) : N_ARG),
        .dec        ((state == ST_RUN) || ((state == ST_SEEK) && !seek_hit)),
        .zero       (dc_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_cmd || (cmd.cmd_op == CMD_NOP) || (is_n && (cmd.cmd_arg == '0)))
                        state_nxt = ST_FIN;
                    else if (cmd.cmd_op == CMD_LOAD)
                        state_nxt = ST_LOAD;
                    else if (is_n)
                        state_nxt = ST_RUN;
                    else
                        state_nxt = ST_SEEK;
                end
            end
            ST_LOAD: state_nxt = ST_FIN;
            ST_RUN:  if (dc_zero) state_nxt = ST_FIN;
            ST_SEEK: if (seek_hit || dc_zero) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // SEEK holds on the matching cycle so the Counter never overshoots the target.
    always_comb begin
        opcode = OPC_HOLD;
        case (state)
            ST_LOAD: opcode = OPC_LOAD;
            ST_RUN:  opcode = step_opcode(op_q);
            ST_SEEK: opcode = (seek_hit || dc_zero) ? OPC_HOLD : step_opcode(op_q);
            default: opcode = OPC_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_sync) begin
            state    <= ST_IDLE;
            op_q     <= CMD_NOP;
            target_q <= '0;
            data_q   <= '0;
            wrap_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= cmd.cmd_op;
                target_q <= cmd.cmd_arg[WIDTH-1:0];
                err_q    <= bad_cmd;
                wrap_q   <= '0;
                if (cmd.cmd_op == CMD_LOAD)
                    data_q <= cmd.cmd_arg[WIDTH-1:0];
            end else begin
                if ((state == ST_SEEK) && !seek_hit && dc_zero)
                    err_q <= 1'b1;
                if (counting && cnt_y && (wrap_q != '1))
                    wrap_q <= wrap_q + 1'b1;
            end
        end
    end

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FIN);
    assign err           = err_q;
    assign wrap_cnt      = wrap_q;
    assign data          = data_q;
endmodule

// File: tb/tb_counter_cmd_driver.sv
// Directed bench for counter_cmd_driver with a behavioural modulo-9 Counter and a done-driven scoreboard.
module tb_counter_cmd_driver;
    logic       clk = 1'b0;
    logic       reset_sync;
    logic [3:0] cnt_result = 4'd0;
    logic       cnt_y = 1'b0;
    logic [2:0] opcode;
    logic [3:0] data;
    logic       busy, done, err;
    logic [7:0] wrap_cnt;

    counter_cmd_driver_if #(.ARG_WIDTH(8)) cmd_if ();

    counter_cmd_driver #(.N(9), .WIDTH(4), .ARG_WIDTH(8)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .cmd        (cmd_if),
        .cnt_result (cnt_result),
        .cnt_y      (cnt_y),
        .opcode     (opcode),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    // Reference modulo-9 Counter; y pulses in the cycle after a wrapping step.
    always @(posedge clk) begin
        cnt_y <= 1'b0;
        case (opcode)
            3'd1: cnt_result <= 4'(data % 4'd9);
            3'd3: if (cnt_result == 4'd8) begin cnt_result <= 4'd0; cnt_y <= 1'b1; end
                  else cnt_result <= cnt_result + 4'd1;
            3'd4: if (cnt_result == 4'd0) begin cnt_result <= 4'd8; cnt_y <= 1'b1; end
                  else cnt_result <= cnt_result - 4'd1;
            default: ;
        endcase
    end

    typedef struct {
        logic       err;
        logic [7:0] wrap;
        logic [3:0] res;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int cyc, n_load, n_up, n_down, n_hold;
    logic [3:0] load_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_done(input logic e, input logic [7:0] w, input logic [3:0] r);
        exp_t x;
        x.err = e; x.wrap = w; x.res = r;
        sb_q.push_back(x);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] arg);
        int w;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        w = 0;
        while (!cmd_if.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        cyc = 0; n_load = 0; n_up = 0; n_down = 0; n_hold = 0; load_data = 4'd0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (opcode == 3'd1) begin n_load++; load_data = data; end
            if (opcode == 3'd3) n_up++;
            if (opcode == 3'd4) n_down++;
            if (opcode == 3'd2 && !done) n_hold++;
            if (done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
    endtask

    initial begin
        reset_sync       = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_arg   = 8'd0;

        fork
            forever begin
                @(negedge clk);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        exp_t x;
                        x = sb_q.pop_front();
                        check("sb_err", int'(err), int'(x.err));
                        check("sb_wrap_cnt", int'(wrap_cnt), int'(x.wrap));
                        check("sb_cnt_result", int'(cnt_result), int'(x.res));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_opcode", int'(opcode), 2);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_wrap", int'(wrap_cnt), 0);
        check("rst_data", int'(data), 0);
        reset_sync = 1'b1;

        // Abort UP_N 20 with a 3-cycle reset; no done may follow.
        issue(3'd3, 8'd20);
        repeat (5) @(negedge clk);
        check("midrun_busy", int'(busy), 1);
        reset_sync = 1'b0;
        @(posedge clk);
        #1;
        check("abort_opcode", int'(opcode), 2);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(cmd_if.cmd_ready), 1);
        check("abort_wrap", int'(wrap_cnt), 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
        end
        @(negedge clk);
        reset_sync = 1'b1;

        expect_done(1'b0, 8'd0, 4'd2);
        issue(3'd1, 8'd2);
        wait_done();
        check("load_cycles", n_load, 1);
        check("load_data", int'(load_data), 2);
        check("load_latency", cyc, 2);

        expect_done(1'b0, 8'd1, 4'd2);
        issue(3'd3, 8'd9);
        wait_done();
        check("upn_up_cycles", n_up, 9);
        check("upn_latency", cyc, 10);

        expect_done(1'b0, 8'd1, 4'd7);
        issue(3'd6, 8'd7);
        wait_done();
        check("seek_down_cycles", n_down, 4);
        check("seek_hold_on_match", n_hold, 1);
        check("seek_latency", cyc, 6);

        expect_done(1'b1, 8'd0, 4'd7);
        issue(3'd5, 8'd13);
        wait_done();
        check("bad_target_latency", cyc, 1);
        check("bad_target_steps", n_up + n_down, 0);
        @(negedge clk);
        check("err_held", int'(err), 1);

        expect_done(1'b1, 8'd0, 4'd7);
        issue(3'd7, 8'd0);
        wait_done();
        check("rsvd_latency", cyc, 1);
        check("rsvd_steps", n_up + n_down, 0);

        // HOLD_N 0 with cmd_valid left high into a following UP_N 3.
        expect_done(1'b0, 8'd0, 4'd7);
        expect_done(1'b0, 8'd1, 4'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd2;
        cmd_if.cmd_arg   = 8'd0;
        @(posedge clk);
        #1;
        cmd_if.cmd_op  = 3'd3;
        cmd_if.cmd_arg = 8'd3;
        @(negedge clk);
        check("b2b_done", int'(done), 1);
        check("b2b_ready_busy", int'(cmd_if.cmd_ready), 0);
        check("b2b_busy", int'(busy), 1);
        @(negedge clk);
        check("b2b_ready_idle", int'(cmd_if.cmd_ready), 1);
        check("b2b_no_done", int'(done), 0);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        wait_done();
        check("b2b_up_cycles", n_up, 3);
        check("b2b_latency", cyc, 4);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
